// File: rtl/popcount_frame_stats.sv
// Frame statistics over a popcount sample stream: sum, max, min and count per frame.
// Optional POPCOUNT_FRAME_STATS_THRESH_EN adds a per-frame count of samples >= thresh_i.
//
// state    | meaning
// ---------+-------------------------------------
// ST_EMPTY | no samples held
// ST_ACCUM | 1..FRAME_LEN-1 samples held
module popcount_frame_stats #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(WIDTH + 1),
   parameter int LEN_W     = $clog2(FRAME_LEN + 1),
   parameter int SUM_W     = CNT_W + LEN_W
) (
   input  logic             clk,
   input  logic             arst_n_i,
   input  logic [CNT_W-1:0] data_i,
   input  logic             data_val_i,
   input  logic             flush_i,
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
   input  logic [CNT_W-1:0] thresh_i,
   output logic [LEN_W-1:0] hit_o,
`endif
   output logic [SUM_W-1:0] sum_o,
   output logic [CNT_W-1:0] max_o,
   output logic [CNT_W-1:0] min_o,
   output logic [LEN_W-1:0] len_o,
   output logic             stat_val_o
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [SUM_W-1:0] acc_sum, cap_sum, frame_sum;
   logic [CNT_W-1:0] acc_max, cap_max, frame_max;
   logic [CNT_W-1:0] acc_min, cap_min, frame_min;
   logic [LEN_W-1:0] acc_len, cap_len, frame_len;
   logic             close;
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
   logic [LEN_W-1:0] acc_hit, cap_hit, frame_hit;
`endif

   always_ff @(posedge clk or negedge arst_n_i) begin
      if (!arst_n_i) state_q <= ST_EMPTY;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (close)           state_d = ST_EMPTY;
      else if (data_val_i) state_d = ST_ACCUM;
   end

   // cap_* is the frame including the current sample; frame_* is what a close reports.
   always_comb begin
      if (state_q == ST_EMPTY) begin
         cap_sum = SUM_W'(data_i);
         cap_max = data_i;
         cap_min = data_i;
         cap_len = LEN_W'(1);
      end else begin
         cap_sum = acc_sum + SUM_W'(data_i);
         cap_max = (data_i > acc_max) ? data_i : acc_max;
         cap_min = (data_i < acc_min) ? data_i : acc_min;
         cap_len = acc_len + LEN_W'(1);
      end
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
      cap_hit = ((state_q == ST_EMPTY) ? '0 : acc_hit) + LEN_W'(data_i >= thresh_i);
      frame_hit = data_val_i ? cap_hit : acc_hit;
`endif
      frame_sum = data_val_i ? cap_sum : acc_sum;
      frame_max = data_val_i ? cap_max : acc_max;
      frame_min = data_val_i ? cap_min : acc_min;
      frame_len = data_val_i ? cap_len : acc_len;
      close = (data_val_i && (cap_len == LEN_W'(FRAME_LEN))) ||
              (flush_i && (data_val_i || (state_q == ST_ACCUM)));
   end

   always_ff @(posedge clk or negedge arst_n_i) begin
      if (!arst_n_i) begin
         acc_sum    <= '0;
         acc_max    <= '0;
         acc_min    <= '0;
         acc_len    <= '0;
         sum_o      <= '0;
         max_o      <= '0;
         min_o      <= '0;
         len_o      <= '0;
         stat_val_o <= 1'b0;
      end else if (close) begin
         sum_o      <= frame_sum;
         max_o      <= frame_max;
         min_o      <= frame_min;
         len_o      <= frame_len;
         stat_val_o <= 1'b1;
         acc_sum    <= '0;
         acc_max    <= '0;
         acc_min    <= '0;
         acc_len    <= '0;
      end else begin
         stat_val_o <= 1'b0;
         if (data_val_i) begin
            acc_sum <= cap_sum;
            acc_max <= cap_max;
            acc_min <= cap_min;
            acc_len <= cap_len;
         end
      end
   end

`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
   always_ff @(posedge clk or negedge arst_n_i) begin
      if (!arst_n_i) begin
         acc_hit <= '0;
         hit_o   <= '0;
      end else if (close) begin
         hit_o   <= frame_hit;
         acc_hit <= '0;
      end else if (data_val_i) begin
         acc_hit <= cap_hit;
      end
   end
`endif

endmodule

// File: tb/tb_popcount_frame_stats.sv
// Scoreboard bench for popcount_frame_stats with WIDTH=16, FRAME_LEN=4.
// Covers the thresh_i/hit_o ports when POPCOUNT_FRAME_STATS_THRESH_EN is defined.
module tb_popcount_frame_stats;
   localparam int WIDTH     = 16;
   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = $clog2(WIDTH + 1);
   localparam int LEN_W     = $clog2(FRAME_LEN + 1);
   localparam int SUM_W     = CNT_W + LEN_W;
   localparam int THRESH    = 10;

   logic             clk = 1'b0;
   logic             arst_n_i = 1'b0;
   logic [CNT_W-1:0] data_i = '0;
   logic             data_val_i = 1'b0;
   logic             flush_i = 1'b0;
   logic [SUM_W-1:0] sum_o;
   logic [CNT_W-1:0] max_o, min_o;
   logic [LEN_W-1:0] len_o;
   logic             stat_val_o;
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
   logic [CNT_W-1:0] thresh_i = CNT_W'(THRESH);
   logic [LEN_W-1:0] hit_o;
`endif

   popcount_frame_stats #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
      .clk        (clk),
      .arst_n_i   (arst_n_i),
      .data_i     (data_i),
      .data_val_i (data_val_i),
      .flush_i    (flush_i),
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
      .thresh_i   (thresh_i),
      .hit_o      (hit_o),
`endif
      .sum_o      (sum_o),
      .max_o      (max_o),
      .min_o      (min_o),
      .len_o      (len_o),
      .stat_val_o (stat_val_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int sum;
      int mx;
      int mn;
      int len;
      int hit;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_pulse = 0;
   int   m_sum = 0, m_max = 0, m_min = 0, m_len = 0, m_hit = 0;
   int   last_sum = 0, last_max = 0, last_min = 0, last_len = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (arst_n_i && stat_val_o) begin
         n_pulse++;
         if (q.size() == 0) begin
            check("spurious_pulse", int'(stat_val_o), 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("sum", int'(sum_o), e.sum);
            check("max", int'(max_o), e.mx);
            check("min", int'(min_o), e.mn);
            check("len", int'(len_o), e.len);
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
            check("hit", int'(hit_o), e.hit);
`endif
            last_sum = int'(sum_o);
            last_max = int'(max_o);
            last_min = int'(min_o);
            last_len = int'(len_o);
         end
      end
   end

   // Drive one cycle of stimulus and advance the reference model.
   task automatic drive(input bit val, input int d, input bit fl);
      bit   cl;
      exp_t e;
      @(posedge clk);
      #1;
      data_val_i = val;
      data_i     = CNT_W'(d);
      flush_i    = fl;
      if (val) begin
         if (m_len == 0) begin
            m_sum = d; m_max = d; m_min = d; m_hit = (d >= THRESH) ? 1 : 0;
         end else begin
            m_sum += d;
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
            if (d >= THRESH) m_hit++;
         end
         m_len++;
      end
      cl = (val && m_len == FRAME_LEN) || (fl && m_len > 0);
      if (cl) begin
         e.cyc = cyc + 1; e.sum = m_sum; e.mx = m_max; e.mn = m_min;
         e.len = m_len; e.hit = m_hit;
         q.push_back(e);
         m_len = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      arst_n_i   = 1'b0;
      data_val_i = 1'b0;
      flush_i    = 1'b0;
      m_len      = 0;
      q.delete();
      #1;
      check("rst_sum", int'(sum_o), 0);
      check("rst_max", int'(max_o), 0);
      check("rst_min", int'(min_o), 0);
      check("rst_len", int'(len_o), 0);
      check("rst_val", int'(stat_val_o), 0);
`ifdef POPCOUNT_FRAME_STATS_THRESH_EN
      check("rst_hit", int'(hit_o), 0);
`endif
      #9;
      arst_n_i = 1'b1;
   endtask

   initial begin
      int np;
      #2;
      check("init_sum", int'(sum_o), 0);
      check("init_len", int'(len_o), 0);
      check("init_val", int'(stat_val_o), 0);
      #11;
      arst_n_i = 1'b1;

      drive(1, 3, 0); drive(1, 16, 0); drive(1, 0, 0); drive(1, 7, 0);
      idle(2);
      check("plan1_sum", last_sum, 26);
      check("plan1_max", last_max, 16);
      check("plan1_min", last_min, 0);

      drive(1, 3, 0); idle(2); drive(1, 16, 0); idle(2);
      drive(1, 0, 0); idle(2); drive(1, 7, 0); idle(2);

      drive(1, 5, 0); drive(1, 9, 1);
      idle(2);
      check("flush_sum", last_sum, 14);
      check("flush_len", last_len, 2);
      drive(1, 1, 0); drive(1, 1, 0); drive(1, 1, 0); drive(1, 1, 0);
      idle(2);

      np = n_pulse;
      drive(0, 0, 1); idle(2);
      check("empty_flush_nopulse", n_pulse, np);
      check("hold_sum", int'(sum_o), 4);
      check("hold_len", int'(len_o), 4);
      check("hold_max", int'(max_o), 1);

      drive(1, 8, 0); drive(1, 8, 0);
      pulse_reset();
      drive(1, 2, 0); drive(1, 2, 0); drive(1, 2, 0); drive(1, 2, 0);
      idle(2);
      check("post_rst_sum", last_sum, 8);
      check("post_rst_min", last_min, 2);

      for (int i = 0; i < 8; i++) drive(1, 16, 0);
      idle(2);

      // Flush sitting in ACCUM with no sample in the closing cycle.
      drive(1, 6, 0); drive(1, 11, 0); drive(0, 0, 1); idle(2);
      check("accum_flush_len", last_len, 2);

      for (int i = 0; i < 300; i++)
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, WIDTH)),
               ($urandom_range(0, 9) == 0));
      idle(4);
      check("pending_pulses", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d cycles expected completion", cyc);
      $fatal(1);
   end
endmodule

// File: doc/popcount_frame_stats.md
Name: popcount_frame_stats

Overview:
- Downstream consumer of the bit population counter stage.
- Takes its stream of per-word popcount results (data_i / data_val_i) and groups them into frames of FRAME_LEN valid samples.
- At each frame boundary, emits one result beat carrying the frame sum, maximum, minimum and sample count.
- Feeds the statistics/reporting logic that sits after the counter.

Parameters:
- WIDTH, 16: data width of the upstream counter. Popcount samples range 0..WIDTH.
- FRAME_LEN, 8: valid samples per frame. Must be >= 1.
- CNT_W, $clog2(WIDTH+1): width of one popcount sample.
- LEN_W, $clog2(FRAME_LEN+1): width of the sample counter.
- SUM_W, CNT_W+LEN_W: width of the frame sum.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- arst_n_i  input  1  reset, asynchronous, active-low.
- data_i  input  CNT_W  popcount sample from the counter stage.
- data_val_i  input  1  data_i valid. No backpressure: every asserted cycle is consumed.
- flush_i  input  1  close the current frame early.
- sum_o  output  SUM_W  sum of samples in the closed frame.
- max_o  output  CNT_W  largest sample in the frame.
- min_o  output  CNT_W  smallest sample in the frame.
- len_o  output  LEN_W  number of samples in the frame.
- stat_val_o  output  1  one-cycle pulse; outputs valid only in this cycle.

Behaviour:
- Reset: arst_n_i low clears all state immediately, independent of clk.
  - All outputs go to 0; stat_val_o = 0; FSM = EMPTY.
  - A partial frame is discarded and no pulse is produced for it.
- FSM states:
  - EMPTY: no samples held.
  - ACCUM: 1..FRAME_LEN-1 samples held.
- Sample capture (data_val_i=1), updating internal registers:
  - acc_sum += data_i
  - acc_max = max(acc_max, data_i)
  - acc_min = min(acc_min, data_i)
  - acc_len += 1
  - The first sample of a frame (state EMPTY) loads all registers directly.
- Frame close occurs in the cycle where either:
  - a valid sample brings acc_len to FRAME_LEN, or
  - flush_i=1 and the frame holds at least 1 sample, counting a sample arriving in the same cycle.
- Close behaviour:
  - On the next rising edge, sum_o/max_o/min_o/len_o take the final values, including the closing-cycle sample. stat_val_o=1 for exactly one cycle.
  - Latency: 1 cycle from the closing sample to stat_val_o.
  - Accumulators return to EMPTY on the same edge. A sample arriving in the cycle after the close starts the next frame; back-to-back frames lose no samples.
- Holding and limits:
  - Outputs hold their last values while stat_val_o=0.
  - FRAME_LEN=1: every valid sample produces a pulse with sum=max=min=sample and len=1.
  - flush_i in EMPTY with data_val_i=0 is ignored: no pulse and no state change.
  - Arithmetic is unsigned. The sum cannot overflow: the worst case WIDTH*FRAME_LEN fits in SUM_W.
  - Samples > WIDTH are illegal input. There is no clamping; results follow the plain arithmetic.
- Gaps (data_val_i=0) between samples are allowed and do not affect results or the frame boundary.

Optional Feature:
- Macro: POPCOUNT_FRAME_STATS_THRESH_EN.
- When defined, adds:
  - thresh_i  input  CNT_W
  - hit_o  output  LEN_W: count of frame samples with data_i >= thresh_i, compared at capture time.
- hit_o follows the same rules as the other outputs: updated on close, 0 on reset, held between pulses.
- When not defined, neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- WIDTH=16, FRAME_LEN=4; samples 3,16,0,7 on consecutive cycles -> one cycle after the 4th sample: stat_val_o=1, sum_o=26, max_o=16, min_o=0, len_o=4.
- Same samples with 2 idle cycles between each -> identical values; pulse exactly 1 cycle after the 4th valid.
- Samples 5,9 with flush_i=1 in the cycle of 9 -> sum_o=14, max_o=9, min_o=5, len_o=2. Then 1,1,1,1 -> sum_o=4, len_o=4.
- flush_i=1 with no samples held and data_val_i=0 -> no pulse; outputs unchanged.
- Two samples (8,8), then arst_n_i low mid-cycle for 1 cycle, then 2,2,2,2 -> outputs 0 during reset; a single pulse with sum_o=8, len_o=4, max_o=min_o=2.
- 8 contiguous samples of 16 -> two pulses 4 cycles apart, each with sum_o=64 and len_o=4. With the macro defined and thresh_i=10, hit_o=4 on both pulses.
